// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C register-file target.
package i2c_target_pkg;

   localparam int I2cSyncStages = 2;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      PTR,
      WDATA,
      WACK,
      RDATA,
      RACK,
      WAIT_STOP
   } i2c_tgt_state_e;

endpackage

// File: rtl/i2c_bus_cond.sv
// Synchronises the asynchronous SCL/SDA pins into clk_i and decodes
// one-cycle bus events from the synced value versus a one-flop history.
module i2c_bus_cond
   import i2c_target_pkg::*;
(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_det_o,
   output logic stop_det_o,
   output logic sda_sync_o
);

   logic [I2cSyncStages-1:0] r_scl_sync;
   logic [I2cSyncStages-1:0] r_sda_sync;
   logic                     r_scl_hist;
   logic                     r_sda_hist;
   logic                     w_scl;
   logic                     w_sda;

   assign w_scl = r_scl_sync[I2cSyncStages-1];
   assign w_sda = r_sda_sync[I2cSyncStages-1];

   // Reset to the idle bus level so leaving reset never fabricates an edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_scl_sync <= '1;
         r_sda_sync <= '1;
         r_scl_hist <= 1'b1;
         r_sda_hist <= 1'b1;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge value of its source.
         r_scl_sync <= {r_scl_sync[I2cSyncStages-2:0], scl_i};
         r_sda_sync <= {r_sda_sync[I2cSyncStages-2:0], sda_i};
         r_scl_hist <= w_scl;
         r_sda_hist <= w_sda;
      end
   end

   assign scl_rise_o  = w_scl & ~r_scl_hist;
   assign scl_fall_o  = ~w_scl & r_scl_hist;
   assign start_det_o = w_scl & r_scl_hist & r_sda_hist & ~w_sda;
   assign stop_det_o  = w_scl & r_scl_hist & ~r_sda_hist & w_sda;
   assign sda_sync_o  = w_sda;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing an 8-bit register file behind an auto-incrementing
// pointer; open-drain outputs, no clock stretching.
module i2c_target_regs
   import i2c_target_pkg::*;
#(
   parameter logic [6:0] TargetAddr = 7'h50,
   parameter int         NumRegs    = 16,
   localparam int        PtrW       = $clog2(NumRegs)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            scl_i,
   input  logic            sda_i,
   output logic            scl_o,
   output logic            sda_o,
   output logic            busy_o,
   output logic            wr_pulse_o,
   output logic [PtrW-1:0] wr_idx_o,
   output logic [7:0]      wr_data_o
);

   i2c_tgt_state_e  r_state, w_state_nxt;
   logic [7:0]      r_shift;
   logic [2:0]      r_cnt;
   logic [PtrW-1:0] r_ptr;
   logic            r_phase;
   logic            r_nack;
   logic            r_sda;
   logic            r_busy;
   logic            r_wr_pulse;
   logic [PtrW-1:0] r_wr_idx;
   logic [7:0]      r_wr_data;
   logic [7:0]      r_regs [NumRegs];

   logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda_sync;
   logic [7:0] w_byte, w_rd_byte;
   logic w_sda_nxt, w_phase_nxt;
   logic w_cnt_clr, w_cnt_inc, w_shift_in, w_rd_ld, w_rd_shift;
   logic w_ptr_ld, w_ptr_inc, w_wr_en, w_nack_we, w_busy_set, w_busy_clr;

   i2c_bus_cond u_bus_cond (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .scl_i       (scl_i),
      .sda_i       (sda_i),
      .scl_rise_o  (w_scl_rise),
      .scl_fall_o  (w_scl_fall),
      .start_det_o (w_start),
      .stop_det_o  (w_stop),
      .sda_sync_o  (w_sda_sync)
   );

   assign w_byte    = {r_shift[6:0], w_sda_sync};
   assign w_rd_byte = r_regs[r_ptr];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   // Acknowledge-type states span two SCL falls; r_phase marks the first one.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      w_state_nxt = r_state;
      w_sda_nxt   = r_sda;
      w_phase_nxt = r_phase;
      w_cnt_clr   = 1'b0;
      w_cnt_inc   = 1'b0;
      w_shift_in  = 1'b0;
      w_rd_ld     = 1'b0;
      w_rd_shift  = 1'b0;
      w_ptr_ld    = 1'b0;
      w_ptr_inc   = 1'b0;
      w_wr_en     = 1'b0;
      w_nack_we   = 1'b0;
      w_busy_set  = 1'b0;
      w_busy_clr  = 1'b0;
      if (w_start || w_stop) begin
         w_state_nxt = w_start ? ADDR : IDLE;
         w_sda_nxt   = 1'b1;
         w_phase_nxt = 1'b0;
         w_cnt_clr   = 1'b1;
         w_busy_clr  = 1'b1;
      end else begin
         case (r_state)
            ADDR, PTR, WDATA: begin
               if (w_scl_rise) begin
                  w_shift_in = 1'b1;
                  w_cnt_inc  = 1'b1;
                  if (r_cnt == 3'd7) begin
                     if (r_state == ADDR) begin
                        if (w_byte[7:1] == TargetAddr) begin
                           w_state_nxt = ADDR_ACK;
                           w_busy_set  = 1'b1;
                        end else begin
                           w_state_nxt = IDLE;
                        end
                     end else begin
                        w_state_nxt = WACK;
                        w_ptr_ld    = (r_state == PTR);
                        w_wr_en     = (r_state == WDATA);
                        w_ptr_inc   = (r_state == WDATA);
                     end
                  end
               end
            end
            ADDR_ACK, WACK: begin
               if (w_scl_fall) begin
                  if (!r_phase) begin
                     w_sda_nxt   = 1'b0;
                     w_phase_nxt = 1'b1;
                  end else begin
                     w_phase_nxt = 1'b0;
                     w_cnt_clr   = 1'b1;
                     if (r_state == ADDR_ACK && r_shift[0]) begin
                        w_rd_ld     = 1'b1;
                        w_sda_nxt   = w_rd_byte[7];
                        w_state_nxt = RDATA;
                     end else begin
                        w_sda_nxt   = 1'b1;
                        w_state_nxt = (r_state == ADDR_ACK) ? PTR : WDATA;
                     end
                  end
               end
            end
            RDATA: begin
               if (w_scl_rise) begin
                  w_cnt_inc = 1'b1;
                  if (r_cnt == 3'd7) w_state_nxt = RACK;
               end else if (w_scl_fall) begin
                  w_rd_shift = 1'b1;
                  w_sda_nxt  = r_shift[7];
               end
            end
            RACK: begin
               if (w_scl_fall && !r_phase) begin
                  w_sda_nxt   = 1'b1;
                  w_ptr_inc   = 1'b1;
                  w_phase_nxt = 1'b1;
               end else if (w_scl_rise && r_phase) begin
                  w_nack_we = 1'b1;
               end else if (w_scl_fall) begin
                  w_phase_nxt = 1'b0;
                  if (r_nack) begin
                     w_state_nxt = WAIT_STOP;
                  end else begin
                     w_rd_ld     = 1'b1;
                     w_sda_nxt   = w_rd_byte[7];
                     w_cnt_clr   = 1'b1;
                     w_state_nxt = RDATA;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_shift    <= '0;
         r_cnt      <= '0;
         r_ptr      <= '0;
         r_phase    <= 1'b0;
         r_nack     <= 1'b0;
         r_sda      <= 1'b1;
         r_busy     <= 1'b0;
         r_wr_pulse <= 1'b0;
         r_wr_idx   <= '0;
         r_wr_data  <= '0;
         // NOTE: the register file must read back zero after reset, so it cannot map to RAM.
         for (int i = 0; i < NumRegs; i++) r_regs[i] <= '0;
      end else begin
         r_phase    <= w_phase_nxt;
         r_sda      <= w_sda_nxt;
         r_wr_pulse <= w_wr_en;
         if (w_cnt_clr)      r_cnt <= '0;
         else if (w_cnt_inc) r_cnt <= r_cnt + 3'd1;
         if (w_shift_in)      r_shift <= w_byte;
         else if (w_rd_ld)    r_shift <= {w_rd_byte[6:0], 1'b0};
         else if (w_rd_shift) r_shift <= {r_shift[6:0], 1'b0};
         if (w_busy_clr)      r_busy <= 1'b0;
         else if (w_busy_set) r_busy <= 1'b1;
         if (w_ptr_ld)       r_ptr <= w_byte[PtrW-1:0];
         else if (w_ptr_inc) r_ptr <= r_ptr + 1'b1;
         if (w_nack_we) r_nack <= w_sda_sync;
         if (w_wr_en) begin
            r_regs[r_ptr] <= w_byte;
            r_wr_idx      <= r_ptr;
            r_wr_data     <= w_byte;
         end
      end
   end

   assign scl_o      = 1'b1;
   assign sda_o      = r_sda;
   assign busy_o     = r_busy;
   assign wr_pulse_o = r_wr_pulse;
   assign wr_idx_o   = r_wr_idx;
   assign wr_data_o  = r_wr_data;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged controller on a wired-AND bus,
// directed table, corner-case sequences and a randomized register-file model.
module tb_i2c_target_regs;

   localparam int NREGS = 16;
   localparam int QCLK  = 5;

   typedef struct {
      bit         rd;
      bit         setp;
      logic [6:0] a7;
      logic [7:0] p;
      int         n;
      logic [7:0] b0, b1;
      logic [3:0] i0, i1;
      int         acks;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ctl_scl = 1'b1;
   logic       ctl_sda = 1'b1;
   logic       bus_scl, bus_sda;
   logic       scl_o, sda_o, busy_o, wr_pulse_o;
   logic [3:0] wr_idx_o;
   logic [7:0] wr_data_o;

   int total = 0;
   int bad   = 0;
   int sda_low_cnt = 0;
   int busy_cnt    = 0;
   logic [11:0] pulse_log [$];
   int pl_base = 0;

   logic [7:0] mdl_regs [NREGS];
   int         mdl_ptr;

   assign bus_scl = ctl_scl & scl_o;
   assign bus_sda = ctl_sda & sda_o;

   i2c_target_regs dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .scl_i      (bus_scl),
      .sda_i      (bus_sda),
      .scl_o      (scl_o),
      .sda_o      (sda_o),
      .busy_o     (busy_o),
      .wr_pulse_o (wr_pulse_o),
      .wr_idx_o   (wr_idx_o),
      .wr_data_o  (wr_data_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_pulse_o) pulse_log.push_back({wr_idx_o, wr_data_o});
      if (!sda_o) sda_low_cnt++;
      if (busy_o) busy_cnt++;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic q_wait();
      repeat (QCLK) @(negedge clk);
   endtask

   task automatic bus_bit(input logic b, output logic s);
      ctl_sda = b;
      q_wait();
      ctl_scl = 1'b1;
      q_wait();
      q_wait();
      s = bus_sda;
      ctl_scl = 1'b0;
      q_wait();
   endtask

   task automatic i2c_start();
      ctl_sda = 1'b1; q_wait();
      ctl_scl = 1'b1; q_wait();
      ctl_sda = 1'b0; q_wait();
      ctl_scl = 1'b0; q_wait();
   endtask

   task automatic i2c_stop();
      ctl_sda = 1'b0; q_wait();
      ctl_scl = 1'b1; q_wait();
      ctl_sda = 1'b1; q_wait();
   endtask

   task automatic wr_byte(input logic [7:0] b, output bit ack);
      logic s;
      for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
      bus_bit(1'b1, s);
      ack = !s;
   endtask

   task automatic rd_byte(input bit ack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bus_bit(1'b1, s);
         d[i] = s;
      end
      bus_bit(!ack, s);
   endtask

   task automatic xfer(input bit rd, input bit setp, input logic [6:0] a7, input logic [7:0] p,
                       input int n, input logic [3:0][7:0] wd,
                       output int acks, output logic [3:0][7:0] rdd);
      bit a;
      logic [7:0] b8;
      acks = 0;
      rdd  = '0;
      i2c_start();
      if (!rd || setp) begin
         wr_byte({a7, 1'b0}, a); acks += int'(a);
         wr_byte(p, a);          acks += int'(a);
      end
      if (!rd) begin
         for (int k = 0; k < n; k++) begin
            wr_byte(wd[k], a);
            acks += int'(a);
         end
      end else begin
         if (setp) i2c_start();
         wr_byte({a7, 1'b1}, a); acks += int'(a);
         for (int k = 0; k < n; k++) begin
            rd_byte(k != n - 1, b8);
            rdd[k] = b8;
         end
      end
      i2c_stop();
      repeat (4) @(negedge clk);
   endtask

   task automatic cmp_pulses(input string tag, input int n, input logic [3:0][11:0] exp);
      int got;
      got = pulse_log.size() - pl_base;
      check({tag, "_npulse"}, got, n);
      for (int k = 0; k < n && k < got; k++) check({tag, "_pulse"}, pulse_log[pl_base + k], exp[k]);
      pl_base = pulse_log.size();
   endtask

   task automatic mdl_write(input logic [7:0] p, input int n, input logic [3:0][7:0] wd,
                            output logic [3:0][11:0] exp);
      exp = '0;
      mdl_ptr = int'(p) % NREGS;
      for (int k = 0; k < n; k++) begin
         exp[k] = {4'(mdl_ptr), wd[k]};
         mdl_regs[mdl_ptr] = wd[k];
         mdl_ptr = (mdl_ptr + 1) % NREGS;
      end
   endtask

   task automatic mdl_read(input bit setp, input logic [7:0] p, input int n,
                           output logic [3:0][7:0] exp);
      exp = '0;
      if (setp) mdl_ptr = int'(p) % NREGS;
      for (int k = 0; k < n; k++) begin
         exp[k] = mdl_regs[mdl_ptr];
         mdl_ptr = (mdl_ptr + 1) % NREGS;
      end
   endtask

   initial begin
      vec_t vecs [7];
      int acks, cnt, low0, busy0, n;
      bit a, rd, setp;
      logic s;
      logic [7:0] p;
      logic [3:0][7:0] rdd, wd, exp_d;
      logic [3:0][11:0] exp_p;

      vecs[0] = '{1'b0, 1'b0, 7'h50, 8'h03, 2, 8'h5A, 8'hC3, 4'd3, 4'd4, 4};
      vecs[1] = '{1'b1, 1'b0, 7'h50, 8'h00, 1, 8'h00, 8'h00, 4'd0, 4'd0, 1};
      vecs[2] = '{1'b1, 1'b1, 7'h50, 8'h03, 2, 8'h5A, 8'hC3, 4'd0, 4'd0, 3};
      vecs[3] = '{1'b0, 1'b0, 7'h51, 8'h11, 0, 8'h00, 8'h00, 4'd0, 4'd0, 0};
      vecs[4] = '{1'b0, 1'b0, 7'h50, 8'h0F, 2, 8'h77, 8'h88, 4'd15, 4'd0, 4};
      vecs[5] = '{1'b1, 1'b0, 7'h50, 8'h00, 1, 8'h00, 8'h00, 4'd0, 4'd0, 1};
      vecs[6] = '{1'b1, 1'b1, 7'h50, 8'h1F, 2, 8'h77, 8'h88, 4'd0, 4'd0, 3};

      for (int i = 0; i < NREGS; i++) mdl_regs[i] = 8'h00;
      mdl_ptr = 0;

      repeat (3) @(negedge clk);
      check("rst_sda_o", sda_o, 1);
      check("rst_scl_o", scl_o, 1);
      check("rst_busy", busy_o, 0);
      check("rst_wr_pulse", wr_pulse_o, 0);
      check("rst_wr_idx", wr_idx_o, 0);
      check("rst_wr_data", wr_data_o, 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      for (int v = 0; v < 7; v++) begin
         low0  = sda_low_cnt;
         busy0 = busy_cnt;
         wd    = {16'h0, vecs[v].b1, vecs[v].b0};
         xfer(vecs[v].rd, vecs[v].setp, vecs[v].a7, vecs[v].p, vecs[v].n, wd, acks, rdd);
         check($sformatf("vec%0d_acks", v), acks, vecs[v].acks);
         if (vecs[v].rd) begin
            mdl_read(vecs[v].setp, vecs[v].p, vecs[v].n, exp_d);
            check($sformatf("vec%0d_rd0", v), rdd[0], vecs[v].b0);
            if (vecs[v].n > 1) check($sformatf("vec%0d_rd1", v), rdd[1], vecs[v].b1);
            cmp_pulses($sformatf("vec%0d", v), 0, '0);
         end else if (vecs[v].acks == 0) begin
            check($sformatf("vec%0d_sda_never_low", v), sda_low_cnt - low0, 0);
            check($sformatf("vec%0d_busy_never_high", v), busy_cnt - busy0, 0);
            cmp_pulses($sformatf("vec%0d", v), 0, '0);
         end else begin
            mdl_write(vecs[v].p, vecs[v].n, wd, exp_p);
            cmp_pulses($sformatf("vec%0d", v), vecs[v].n,
                       {24'h0, vecs[v].i1, vecs[v].b1, vecs[v].i0, vecs[v].b0});
         end
      end

      // busy_o must drop a few cycles after STOP
      i2c_start();
      wr_byte(8'hA0, a);
      check("busy_seq_addr_ack", a, 1);
      check("busy_after_match", busy_o, 1);
      wr_byte(8'h02, a);
      mdl_ptr = 2;
      ctl_sda = 1'b0; q_wait();
      ctl_scl = 1'b1; q_wait();
      check("busy_before_stop", busy_o, 1);
      ctl_sda = 1'b1;
      cnt = 0;
      while (busy_o && cnt < 8) begin
         @(negedge clk);
         cnt++;
      end
      check("busy_fall_latency_1_to_4", (cnt >= 1 && cnt <= 4), 1);
      repeat (8) @(negedge clk);

      // STOP mid-byte must not commit the partial data byte
      xfer(1'b0, 1'b0, 7'h50, 8'h07, 1, 32'h3C, acks, rdd);
      mdl_write(8'h07, 1, 32'h3C, exp_p);
      cmp_pulses("abort_pre", 1, exp_p);
      i2c_start();
      wr_byte(8'hA0, a);
      wr_byte(8'h07, a);
      mdl_ptr = 7;
      for (int i = 0; i < 5; i++) bus_bit(1'b1, s);
      i2c_stop();
      repeat (4) @(negedge clk);
      cmp_pulses("abort", 0, '0);
      check("abort_busy_cleared", busy_o, 0);
      check("abort_sda_released", sda_o, 1);
      xfer(1'b1, 1'b1, 7'h50, 8'h07, 1, '0, acks, rdd);
      mdl_read(1'b1, 8'h07, 1, exp_d);
      check("abort_next_acks", acks, 3);
      check("abort_reg_unchanged", rdd[0], exp_d[0]);

      for (int it = 0; it < 20; it++) begin
         rd   = 1'($urandom_range(0, 1));
         setp = rd ? 1'($urandom_range(0, 1)) : 1'b1;
         p    = 8'($urandom_range(0, 255));
         n    = $urandom_range(1, 3);
         wd   = $urandom();
         xfer(rd, setp, 7'h50, p, n, wd, acks, rdd);
         if (rd) begin
            mdl_read(setp, p, n, exp_d);
            check($sformatf("rnd%0d_acks", it), acks, setp ? 3 : 1);
            for (int k = 0; k < n; k++) check($sformatf("rnd%0d_rd%0d", it, k), rdd[k], exp_d[k]);
            cmp_pulses($sformatf("rnd%0d", it), 0, '0);
         end else begin
            mdl_write(p, n, wd, exp_p);
            check($sformatf("rnd%0d_acks", it), acks, 2 + n);
            cmp_pulses($sformatf("rnd%0d", it), n, exp_p);
         end
      end

      // asynchronous reset while the target holds the ACK low
      i2c_start();
      p = 8'hA0;
      for (int i = 7; i >= 0; i--) bus_bit(p[i], s);
      check("ack_driven_before_reset", sda_o, 0);
      #1 rst_n = 1'b0;
      #1;
      check("async_reset_sda", sda_o, 1);
      check("async_reset_busy", busy_o, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      i2c_stop();
      repeat (4) @(negedge clk);
      for (int i = 0; i < NREGS; i++) mdl_regs[i] = 8'h00;
      mdl_ptr = 0;
      xfer(1'b1, 1'b1, 7'h50, 8'h03, 2, '0, acks, rdd);
      check("post_reset_acks", acks, 3);
      check("post_reset_reg3", rdd[0], 8'h00);
      check("post_reset_reg4", rdd[1], 8'h00);
      cmp_pulses("post_reset", 0, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
